// File: rtl/video_pll_pkg.sv
// Shared types and helpers for the video PLL sequencer.
// VIDEO_PLL_SEQUENCER_TIMEOUT_EN adds the StFail state.
package video_pll_pkg;

  localparam logic [5:0] DEFAULT_SEL = 6'd60;

  typedef enum logic [2:0] {
    StIdle,
    StResetHold,
    StWaitLock,
    StSettle
`ifdef VIDEO_PLL_SEQUENCER_TIMEOUT_EN
    , StFail
`endif
  } pll_state_e;

  // Input and feedback in 1..63, output even in 2..126.
  function automatic logic divider_set_valid(input logic [15:0] in_div,
                                             input logic [15:0] out_div,
                                             input logic [15:0] fb_div);
    logic in_ok, fb_ok, out_ok;
    in_ok  = (in_div >= 16'd1) && (in_div <= 16'd63);
    fb_ok  = (fb_div >= 16'd1) && (fb_div <= 16'd63);
    out_ok = !out_div[0] && (out_div >= 16'd2) && (out_div <= 16'd126);
    return in_ok && fb_ok && out_ok;
  endfunction

  // PLL select encoding: 64 - divider, 7-bit arithmetic truncated to 6 bits.
  function automatic logic [5:0] encode_sel(input logic [5:0] div);
    logic [6:0] diff;
    diff = 7'd64 - {1'b0, div};
    return diff[5:0];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single-bit level signal; cleared by synchronous reset.
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/video_pll_sequencer.sv
// Sequences PLL reset, lock wait and settle before releasing the video domain reset.
// Define VIDEO_PLL_SEQUENCER_TIMEOUT_EN to add the lock timeout and StFail retry state.
module video_pll_sequencer
  import video_pll_pkg::*;
#(
  parameter int unsigned RESET_HOLD_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES       = 256,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        config_valid,
  output logic        config_ready,
  input  logic [15:0] input_divider,
  input  logic [15:0] output_divider,
  input  logic [15:0] feedback_divider,
  input  logic        pll_lock,
  output logic        pll_reset,
  output logic [5:0]  pll_fbdsel,
  output logic [5:0]  pll_idsel,
  output logic [5:0]  pll_odsel,
  output logic        video_reset_req,
  output logic        busy,
  output logic        error
);

  localparam int unsigned CntMax = (RESET_HOLD_CYCLES > SETTLE_CYCLES) ?
                                   RESET_HOLD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(RESET_HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLast = CntW'(SETTLE_CYCLES - 1);

  pll_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            error_q, error_d;
  logic [5:0]      fbdsel_q, fbdsel_d;
  logic [5:0]      idsel_q, idsel_d;
  logic [5:0]      odsel_q, odsel_d;
  logic            lock_sync;
  logic            accept;
  logic            cfg_ok;

  sync_2ff u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (pll_lock),
    .q     (lock_sync)
  );

`ifdef VIDEO_PLL_SEQUENCER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(LOCK_TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;

  // Counts consecutive WAIT_LOCK cycles; zero on every other state.
  assign tmo_cnt_d = (state_q == StWaitLock) ? tmo_cnt_q + TmoW'(1) : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = LOCK_TIMEOUT_CYCLES;
`endif

  always_comb begin
    pll_reset       = (state_q == StResetHold);
    video_reset_req = (state_q != StIdle);
    busy            = (state_q != StIdle);
    config_ready    = (state_q == StIdle);
`ifdef VIDEO_PLL_SEQUENCER_TIMEOUT_EN
    if (state_q == StFail) config_ready = 1'b1;
`endif
  end

  assign accept = config_valid && config_ready;
  assign cfg_ok = divider_set_valid(input_divider, output_divider, feedback_divider);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    error_d  = error_q;
    fbdsel_d = fbdsel_q;
    idsel_d  = idsel_q;
    odsel_d  = odsel_q;

    unique case (state_q)
      StIdle: begin
        if (!lock_sync) state_d = StWaitLock;
      end
      StResetHold: begin
        if (cnt_q == HoldLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitLock: begin
        if (lock_sync) begin
          // The cycle that sees lock counts as the first settle cycle.
          if (SETTLE_CYCLES <= 1) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            state_d = StSettle;
            cnt_d   = CntW'(1);
          end
        end
`ifdef VIDEO_PLL_SEQUENCER_TIMEOUT_EN
        else if (tmo_cnt_q == TmoLast) begin
          state_d = StFail;
          error_d = 1'b1;
        end
`endif
      end
      StSettle: begin
        if (!lock_sync) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == SettleLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef VIDEO_PLL_SEQUENCER_TIMEOUT_EN
      StFail: begin
        state_d = StResetHold;
        cnt_d   = '0;
      end
`endif
      default: begin
        state_d = StResetHold;
        cnt_d   = '0;
      end
    endcase

    // A rejected set only flags error; an accepted one restarts the sequence.
    if (accept) begin
      if (cfg_ok) begin
        error_d  = 1'b0;
        fbdsel_d = encode_sel(feedback_divider[5:0]);
        idsel_d  = encode_sel(input_divider[5:0]);
        odsel_d  = encode_sel(output_divider[6:1]);
        state_d  = StResetHold;
        cnt_d    = '0;
      end else begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StResetHold;
      cnt_q    <= '0;
      error_q  <= 1'b0;
      fbdsel_q <= DEFAULT_SEL;
      idsel_q  <= DEFAULT_SEL;
      odsel_q  <= DEFAULT_SEL;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      error_q  <= error_d;
      fbdsel_q <= fbdsel_d;
      idsel_q  <= idsel_d;
      odsel_q  <= odsel_d;
    end
  end

  assign error      = error_q;
  assign pll_fbdsel = fbdsel_q;
  assign pll_idsel  = idsel_q;
  assign pll_odsel  = odsel_q;

endmodule

// File: tb/tb_video_pll_sequencer.sv
// Scoreboard bench for video_pll_sequencer: stimulus queues expected events, a monitor checks them.
module tb_video_pll_sequencer;

  localparam int unsigned TmoCycles = 100;

  logic        clock;
  logic        reset;
  logic        config_valid;
  logic        config_ready;
  logic [15:0] input_divider;
  logic [15:0] output_divider;
  logic [15:0] feedback_divider;
  logic        pll_lock;
  logic        pll_reset;
  logic [5:0]  pll_fbdsel;
  logic [5:0]  pll_idsel;
  logic [5:0]  pll_odsel;
  logic        video_reset_req;
  logic        busy;
  logic        error;

  video_pll_sequencer #(
    .RESET_HOLD_CYCLES   (16),
    .SETTLE_CYCLES       (256),
    .LOCK_TIMEOUT_CYCLES (TmoCycles)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .config_valid     (config_valid),
    .config_ready     (config_ready),
    .input_divider    (input_divider),
    .output_divider   (output_divider),
    .feedback_divider (feedback_divider),
    .pll_lock         (pll_lock),
    .pll_reset        (pll_reset),
    .pll_fbdsel       (pll_fbdsel),
    .pll_idsel        (pll_idsel),
    .pll_odsel        (pll_odsel),
    .video_reset_req  (video_reset_req),
    .busy             (busy),
    .error            (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef enum int {EvSnap, EvAccept, EvAssert, EvPulse, EvRelease, EvFail} ev_kind_e;
  typedef struct {
    ev_kind_e    kind;
    logic [31:0] value;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad = 0;

  localparam logic [31:0] SnapReset = {10'd0, 1'b1, 6'd60, 6'd60, 6'd60, 1'b1, 1'b1, 1'b0, 1'b0};

  function automatic void expect_ev(input ev_kind_e kind, input logic [31:0] value);
    ev_t e;
    e.kind  = kind;
    e.value = value;
    exp_q.push_back(e);
  endfunction

  function automatic logic [31:0] acc_val(input logic rdy, input logic err, input logic [5:0] fb,
                                          input logic [5:0] id, input logic [5:0] od);
    return {12'd0, rdy, err, fb, id, od};
  endfunction

  function automatic logic [31:0] rel_val(input int run);
    return (32'(run) << 2) | 32'd2;
  endfunction

  task automatic check_ev(input ev_kind_e kind, input logic [31:0] value);
    ev_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_%s got=0x%0h required=none", kind.name(), value);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.value != value) begin
        bad++;
        $display("FAIL event got=%s/0x%0h required=%s/0x%0h",
                 kind.name(), value, e.kind.name(), e.value);
      end
    end
  endtask

  // Monitor state
  logic acc_pend = 1'b0;
  logic rst_prev = 1'b0;
  logic snap_done = 1'b0;
  logic vrr_prev = 1'b1;
  logic busy_prev = 1'b1;
  int   pulse_len = 0;
  int   run_len = 0;
  int   since_assert = 0;

  always @(negedge clock) begin
    if (acc_pend)
      check_ev(EvAccept, acc_val(config_ready, error, pll_fbdsel, pll_idsel, pll_odsel));
    acc_pend = config_valid && config_ready && !reset;

    if (reset && rst_prev && !snap_done) begin
      check_ev(EvSnap, {10'd0, pll_reset, pll_fbdsel, pll_idsel, pll_odsel,
                        video_reset_req, busy, config_ready, error});
      snap_done = 1'b1;
    end
    if (!reset) snap_done = 1'b0;
    rst_prev = reset;

    if (!reset && vrr_prev === 1'b1 && video_reset_req === 1'b0)
      check_ev(EvRelease, (32'(run_len) << 2) | {30'd0, busy_prev, busy});

    if (!reset && vrr_prev === 1'b0 && video_reset_req === 1'b1) begin
      check_ev(EvAssert, {31'd0, pll_reset});
      since_assert = 1;
    end else begin
      since_assert++;
    end

    if (!reset && busy === 1'b1 && config_ready === 1'b1)
      check_ev(EvFail, {error, 31'(since_assert)});

    if (reset) pulse_len = 0;
    else if (pll_reset) pulse_len++;
    else if (pulse_len != 0) begin
      check_ev(EvPulse, 32'(pulse_len));
      pulse_len = 0;
    end

    if (!reset && pll_lock && !pll_reset && video_reset_req) run_len++;
    else run_len = 0;

    vrr_prev  = video_reset_req;
    busy_prev = busy;
  end

  task automatic send_cfg(input logic [15:0] i, input logic [15:0] o, input logic [15:0] f);
    int n;
    n = 0;
    @(posedge clock);
    #1;
    config_valid     = 1'b1;
    input_divider    = i;
    output_divider   = o;
    feedback_divider = f;
    forever begin
      @(negedge clock);
      if (config_ready) break;
      n++;
      if (n > 3000) break;
    end
    if (n > 3000) begin
      total++;
      bad++;
      $display("FAIL handshake got=no_ready required=ready_within_3000");
    end
    @(posedge clock);
    #1;
    config_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_%s got=%0d_pending required=0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic drop_lock(input int cycles);
    @(posedge clock);
    #1 pll_lock = 1'b0;
    repeat (cycles) @(posedge clock);
    #1 pll_lock = 1'b1;
  endtask

  initial begin
    reset            = 1'b1;
    config_valid     = 1'b0;
    input_divider    = '0;
    output_divider   = '0;
    feedback_divider = '0;
    pll_lock         = 1'b0;

    // Power-on: reset values, 16-cycle pulse, release 2 sync + 256 settle after lock
    expect_ev(EvSnap, SnapReset);
    expect_ev(EvPulse, 32'd16);
    expect_ev(EvRelease, rel_val(258));
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;
    repeat (40) @(posedge clock);
    #1 pll_lock = 1'b1;
    drain("power_on");

    // Valid set 4/8/4 -> all selects 60
    expect_ev(EvAccept, acc_val(1'b0, 1'b0, 6'd60, 6'd60, 6'd60));
    expect_ev(EvAssert, 32'd1);
    expect_ev(EvPulse, 32'd16);
    expect_ev(EvRelease, rel_val(256));
    send_cfg(16'd4, 16'd8, 16'd4);
    drain("cfg_4_8_4");

    // Valid set in=2 out=10 fb=8 -> fb 56, id 62, od 59
    expect_ev(EvAccept, acc_val(1'b0, 1'b0, 6'd56, 6'd62, 6'd59));
    expect_ev(EvAssert, 32'd1);
    expect_ev(EvPulse, 32'd16);
    expect_ev(EvRelease, rel_val(256));
    send_cfg(16'd2, 16'd10, 16'd8);
    drain("cfg_2_10_8");

    // Invalid sets: in=0, then out=7; handshake completes, error set, nothing else moves
    expect_ev(EvAccept, acc_val(1'b1, 1'b1, 6'd56, 6'd62, 6'd59));
    send_cfg(16'd0, 16'd8, 16'd4);
    drain("bad_in0");
    expect_ev(EvAccept, acc_val(1'b1, 1'b1, 6'd56, 6'd62, 6'd59));
    send_cfg(16'd4, 16'd7, 16'd4);
    drain("bad_out7");
    repeat (40) @(posedge clock);

    // Set offered while busy stays pending and is taken in the first IDLE cycle
    expect_ev(EvAccept, acc_val(1'b0, 1'b0, 6'd60, 6'd60, 6'd60));
    expect_ev(EvAssert, 32'd1);
    expect_ev(EvPulse, 32'd16);
    expect_ev(EvRelease, rel_val(256));
    expect_ev(EvAccept, acc_val(1'b0, 1'b0, 6'd59, 6'd61, 6'd58));
    expect_ev(EvAssert, 32'd1);
    expect_ev(EvPulse, 32'd16);
    expect_ev(EvRelease, rel_val(256));
    send_cfg(16'd4, 16'd8, 16'd4);
    repeat (100) @(posedge clock);
    send_cfg(16'd3, 16'd12, 16'd5);
    drain("pending");

    // Lock drop during SETTLE restarts the settle count
    expect_ev(EvAccept, acc_val(1'b0, 1'b0, 6'd60, 6'd60, 6'd60));
    expect_ev(EvAssert, 32'd1);
    expect_ev(EvPulse, 32'd16);
    expect_ev(EvRelease, rel_val(258));
    send_cfg(16'd4, 16'd8, 16'd4);
    repeat (80) @(posedge clock);
    drop_lock(3);
    drain("settle_drop");

    // Lock drop in IDLE -> WAIT_LOCK without a pll_reset pulse
    expect_ev(EvAssert, 32'd0);
    expect_ev(EvRelease, rel_val(258));
    drop_lock(3);
    drain("idle_drop");

    // Reset asserted in WAIT_LOCK with non-default selects and error set
    expect_ev(EvAccept, acc_val(1'b0, 1'b0, 6'd56, 6'd62, 6'd59));
    expect_ev(EvAssert, 32'd1);
    expect_ev(EvPulse, 32'd16);
    expect_ev(EvRelease, rel_val(256));
    send_cfg(16'd2, 16'd10, 16'd8);
    drain("cfg_before_reset");
    expect_ev(EvAccept, acc_val(1'b1, 1'b1, 6'd56, 6'd62, 6'd59));
    send_cfg(16'd5, 16'd7, 16'd5);
    drain("bad_before_reset");
    expect_ev(EvAssert, 32'd0);
    @(posedge clock);
    #1 pll_lock = 1'b0;
    repeat (10) @(posedge clock);
    drain("enter_wait_lock");
    expect_ev(EvSnap, SnapReset);
    expect_ev(EvPulse, 32'd16);
    expect_ev(EvRelease, rel_val(258));
    #1 reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (20) @(posedge clock);
    #1 pll_lock = 1'b1;
    drain("mid_reset");

`ifdef VIDEO_PLL_SEQUENCER_TIMEOUT_EN
    // Lock never returns: FAIL after TmoCycles WAIT_LOCK cycles, then a retry pulse
    expect_ev(EvAssert, 32'd0);
    expect_ev(EvFail, {1'b1, 31'(TmoCycles + 1)});
    expect_ev(EvPulse, 32'd16);
    @(posedge clock);
    #1 pll_lock = 1'b0;
    drain("timeout");
    expect_ev(EvRelease, rel_val(258));
    @(posedge clock);
    #1 pll_lock = 1'b1;
    drain("timeout_recover");
`endif

    repeat (50) @(posedge clock);
    drain("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/video_pll_sequencer.md
VIDEO_PLL_SEQUENCER -- requirements
Module: video_pll_sequencer

Interface
REQ-001 SHALL have parameter RESET_HOLD_CYCLES, default 16: number of cycles pll_reset is held high per sequence.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 256: number of cycles after lock before video reset is released.
REQ-003 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 1_000_000: maximum wait for lock (timeout build only).
REQ-004 SHALL have these ports; one clock; reset is synchronous and active-high:
- clock  in  1  sequencer clock (SDRAM-controller clock)
- reset  in  1  synchronous active-high reset
- config_valid  in  1  new divider set offered
- config_ready  out  1  sequencer can accept a divider set
- input_divider  in  16  PLL input divide; bits [5:0] used
- output_divider  in  16  PLL output divide; bits [6:0] used
- feedback_divider  in  16  PLL feedback divide; bits [5:0] used
- pll_lock  in  1  PLL lock, asynchronous to clock
- pll_reset  out  1  PLL reset
- pll_fbdsel, pll_idsel, pll_odsel  out  6 each  PLL dynamic divider selects
- video_reset_req  out  1  hold the video domain in reset
- busy  out  1  a sequence is in progress
- error  out  1  sticky: last configuration rejected or timed out

Function
REQ-005 SHALL synchronise pll_lock through 2 flops; "lock" below means the synchronised value.
REQ-006 SHALL implement these states: IDLE, RESET_HOLD, WAIT_LOCK, SETTLE, and FAIL (FAIL in timeout build only).
REQ-007 SHALL accept a divider set only in IDLE when config_valid && config_ready; config_ready = (state==IDLE).
REQ-008 SHALL validate a divider set as: input and feedback in 1..63; output even and in 2..126.
REQ-009 SHALL, for an invalid set, complete the handshake, set error, and leave the PLL outputs and state unchanged.
REQ-010 SHALL, for a valid set, clear error and register the encoded selects in the accept cycle:
- fbdsel = 64 - fb[5:0]
- idsel = 64 - in[5:0]
- odsel = 64 - out[6:1]
Arithmetic is 7-bit, truncated to 6 bits. The state then goes to RESET_HOLD.
REQ-011 SHALL, in RESET_HOLD, drive pll_reset=1 for exactly RESET_HOLD_CYCLES cycles, then go to WAIT_LOCK.
REQ-012 SHALL, in WAIT_LOCK, go to SETTLE on the first cycle lock=1.
REQ-013 SHALL, in SETTLE, count SETTLE_CYCLES consecutive lock=1 cycles, then go to IDLE; lock=0 during SETTLE restarts the count in WAIT_LOCK.
REQ-014 SHALL drive video_reset_req=1 in every state except IDLE, and deassert it in the cycle IDLE is entered.
REQ-015 SHALL drive busy=1 in every state except IDLE.
REQ-016 SHALL, if lock falls while in IDLE, go to WAIT_LOCK (video_reset_req=1) without pulsing pll_reset.
REQ-017 SHALL treat config_valid asserted while busy as pending: no loss, no corruption, accepted in the first IDLE cycle.
REQ-018 SHALL keep the pll_*sel outputs stable in all states except the accept cycle.

Reset
REQ-019 SHALL, while reset=1, set:
- pll_reset=1, pll_fbdsel=pll_idsel=pll_odsel=60
- video_reset_req=1, busy=1, config_ready=0, error=0
- synchroniser flops and counters cleared
REQ-020 SHALL, on the first cycle after reset, enter RESET_HOLD with the default selects (power-on sequence).
REQ-021 SHALL abort any sequence when reset is asserted mid-operation, and apply REQ-019 in the next cycle.

Configuration
REQ-022 SHALL, with VIDEO_PLL_SEQUENCER_TIMEOUT_EN defined, go from WAIT_LOCK to FAIL after LOCK_TIMEOUT_CYCLES cycles without lock.
- FAIL sets error and keeps video_reset_req=1.
- FAIL retries by re-entering RESET_HOLD; config_ready=1 in FAIL, so a new set may be accepted instead.
REQ-023 SHALL, without VIDEO_PLL_SEQUENCER_TIMEOUT_EN, wait in WAIT_LOCK indefinitely, and the FAIL state and timeout counter SHALL NOT exist.

Structure
REQ-024 SHALL put the state enum, the DEFAULT_SEL=60 constant, and the divider-validation and select-encode functions in shared package video_pll_pkg.
REQ-025 SHALL instantiate one sub-module, sync_2ff, for the pll_lock synchroniser; all other logic is in one file.

Verification
REQ-026 Reset release, pll_lock rising 40 cycles later -> pll_reset high for 16 cycles, selects=60, video_reset_req falls exactly 256 cycles after synchronised lock.
REQ-027 Accept in=4, out=8, fb=4 in IDLE -> fbdsel=60, idsel=60, odsel=60, reset pulse of 16 cycles, busy until settle done.
REQ-028 Offer in=0 or out=7 -> handshake completes, error=1, selects and state unchanged, no pll_reset pulse.
REQ-029 Drop lock for 3 cycles during SETTLE, and separately in IDLE -> SETTLE count restarts; IDLE goes to WAIT_LOCK with no pll_reset pulse.
REQ-030 With timeout build and LOCK_TIMEOUT_CYCLES=100, lock never asserted -> FAIL at cycle 100, error=1, retry pulse observed; reset asserted mid-WAIT_LOCK -> all outputs equal the REQ-019 values next cycle.
